sha_core_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one SHA round core (the `run`/`ready`/`done` control unit plus datapath) among `NUM_REQ` requesters. It grants exclusive use of the core to one requester at a time and issues the single-cycle `run` pulse to the core. It waits for the core's `done`, then returns a one-cycle completion to the owner. A watchdog aborts the transaction if the core never completes. It sits between the requester-side message/DMA logic and the core's control unit.

---
 rtl/sha_core_arbiter_if.sv | 28 ++
 rtl/sha_core_arbiter.sv | 134 +++++++++++++
 tb/tb_sha_core_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_core_arbiter_if.sv
// Handshake bundle between the requesters, the SHA core control unit and the
// arbiter that shares the core among them.
interface sha_core_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   core_sel;
    logic [NUM_REQ-1:0] rsp_done;
    logic               rsp_err;
    logic               core_run;
    logic               core_ready;
    logic               core_done;
    logic               busy;

    // Arbiter side: consumes requests and core status, drives grants and run.
    modport slave (
        input  req, core_ready, core_done,
        output gnt, core_sel, rsp_done, rsp_err, core_run, busy
    );

    // Environment side: requesters plus the core control unit.
    modport master (
        output req, core_ready, core_done,
        input  gnt, core_sel, rsp_done, rsp_err, core_run, busy
    );
endinterface

// File: rtl/sha_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one SHA round core among NUM_REQ
// requesters: grants one owner, pulses core_run, waits for core_done (or a
// watchdog timeout) and returns a one-cycle completion to the owner.
module sha_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 100
) (
    input  logic               clk,
    input  logic               rst,
    sha_core_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [SEL_W-1:0] PTR_RST   = SEL_W'(NUM_REQ - 1);
    localparam logic [7:0]       WD_LAST   = 8'(TIMEOUT - 1);
    localparam logic [SEL_W:0]   NUM_REQ_W = (SEL_W + 1)'(NUM_REQ);

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;
    logic [7:0]         wd_reg, wd_next;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W:0]     cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic               resp_phase;

    // Round-robin search: first set request starting just after the last owner.
    // cand carries one extra bit so ptr+i never overflows before the wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_reg;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, ptr_reg} + (SEL_W + 1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_found && bus.req[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SEL_W-1:0];
            end
        end
    end

    // Per-requester decode of the winner and of the completion pulse.
    assign resp_phase = (state_reg == ST_DONE) || (state_reg == ST_ERR);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign win_onehot[gi]   = (win_idx == SEL_W'(gi));
            assign bus.rsp_done[gi] = resp_phase & gnt_reg[gi];
        end
    endgenerate

    // State register plus grant, pointer and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            ptr_reg   <= PTR_RST;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            wd_reg    <= wd_next;
        end
    end

    // Next-state logic: grant, run, wait for done or watchdog, then respond.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        wd_next    = wd_reg;
        case (state_reg)
            ST_IDLE: begin
                // A busy core holds every request off; nothing is granted.
                if (win_found && bus.core_ready) begin
                    gnt_next   = win_onehot;
                    sel_next   = win_idx;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                wd_next    = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (wd_reg != 8'hFF) begin
                    wd_next = wd_reg + 8'd1;
                end
                // A completion on the watchdog's last cycle still counts as success.
                if (bus.core_done) begin
                    state_next = ST_DONE;
                end else if (wd_reg == WD_LAST) begin
                    state_next = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                ptr_next   = sel_reg;
                gnt_next   = '0;
                sel_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                gnt_next   = '0;
                sel_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs come only from registered state, never from req or core_done.
    assign bus.gnt      = gnt_reg;
    assign bus.core_sel = sel_reg;
    assign bus.core_run = (state_reg == ST_GRANT);
    assign bus.rsp_err  = (state_reg == ST_ERR);
    assign bus.busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Scoreboard bench for sha_core_arbiter: the driver pushes the expected owner,
// error flag and latency of each transaction; a monitor checks them when the
// DUT pulses core_run and rsp_done. A small core model answers core_run.
module tb_sha_core_arbiter;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha_core_arbiter_if #(.NUM_REQ(N), .SEL_W(SW)) bus ();

    sha_core_arbiter #(.NUM_REQ(N), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int owner;
        bit err;
        int lat;   // cycles from core_run to rsp_done
        int gap;   // required cycles from previous rsp_done to core_run (0 = unchecked)
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   ptr_model  = N - 1;
    int   done_delay = 0;   // WAIT cycles before core_done; negative = never

    function automatic void chk(string name, int act, int req_v);
        checks++;
        if (act != req_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endfunction

    function automatic void fail_msg(string name, int act, int req_v);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
    endfunction

    // Reference round-robin choice: first requester after the last owner.
    function automatic int pick(logic [N-1:0] pat);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr_model + k) % N;
            if (pat[idx]) return idx;
        end
        return -1;
    endfunction

    // Core model: core_done pulses done_delay cycles into WAIT.
    initial begin
        int remaining;
        remaining = 0;
        bus.core_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.core_done = 1'b0;
            if (rst) begin
                remaining = 0;
            end else begin
                if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) bus.core_done = 1'b1;
                end
                if (bus.core_run) remaining = (done_delay < 0) ? 0 : done_delay + 1;
            end
        end
    end

    // Monitor: compares DUT events against the scoreboard queue.
    initial begin
        int   cyc, run_cyc, last_done;
        bit   prev_done, prev_run;
        exp_t e;
        cyc = 0; run_cyc = 0; last_done = -100; prev_done = 0; prev_run = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_done = 0;
                prev_run  = 0;
                last_done = -100;
                continue;
            end
            if (prev_done) begin
                chk("gnt_clear_after_done", int'(bus.gnt), 0);
                chk("busy_clear_after_done", int'(bus.busy), 0);
            end
            if (bus.core_run) begin
                if (prev_run) fail_msg("run_pulse_width", 2, 1);
                if (exp_q.size() == 0) begin
                    fail_msg("unexpected_run", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("gnt_at_run", int'(bus.gnt), 1 << e.owner);
                    chk("core_sel_at_run", int'(bus.core_sel), e.owner);
                    chk("busy_at_run", int'(bus.busy), 1);
                    if (e.gap > 0) chk("b2b_gap", cyc - last_done, e.gap);
                end
                run_cyc = cyc;
            end
            if (bus.rsp_done != '0) begin
                if (exp_q.size() == 0) begin
                    fail_msg("unexpected_rsp_done", int'(bus.rsp_done), 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn owner=%0d err=%0d lat=%0d rsp_done=%b rsp_err=%0d",
                             e.owner, e.err, e.lat, bus.rsp_done, bus.rsp_err);
                    chk("rsp_done_owner", int'(bus.rsp_done), 1 << e.owner);
                    chk("rsp_err", int'(bus.rsp_err), int'(e.err));
                    chk("rsp_latency", cyc - run_cyc, e.lat);
                    chk("gnt_held_at_done", int'(bus.gnt), 1 << e.owner);
                end
                last_done = cyc;
            end
            prev_done = (bus.rsp_done != '0);
            prev_run  = bus.core_run;
        end
    end

    task automatic reset_check(string tag);
        chk({tag, "_gnt"}, int'(bus.gnt), 0);
        chk({tag, "_core_sel"}, int'(bus.core_sel), 0);
        chk({tag, "_rsp_done"}, int'(bus.rsp_done), 0);
        chk({tag, "_rsp_err"}, int'(bus.rsp_err), 0);
        chk({tag, "_core_run"}, int'(bus.core_run), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic idle(int n);
        bus.req = '0;
        repeat (n) @(negedge clk);
    endtask

    // One transaction. With hold>0, core_ready stays low for hold cycles while
    // pat_early is presented, then pat is presented with core_ready high.
    // Returns on the negedge of the rsp_done cycle.
    task automatic run_txn(logic [N-1:0] pat_early, logic [N-1:0] pat, int hold,
                           int k, int gap, bit drop);
        exp_t e;
        int   owner;
        bit   seen;
        if (hold > 0) begin
            bus.core_ready = 1'b0;
            bus.req = pat_early;
            repeat (hold) begin
                @(negedge clk);
                chk("noready_gnt", int'(bus.gnt), 0);
                chk("noready_busy", int'(bus.busy), 0);
            end
        end
        owner   = pick(pat);
        e.owner = owner;
        e.err   = (k < 0) || (k >= TO);
        e.lat   = e.err ? TO + 1 : k + 2;
        e.gap   = gap;
        exp_q.push_back(e);
        ptr_model  = owner;
        done_delay = k;
        bus.req = pat;
        bus.core_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = bus.core_run;
        end
        if (!seen) begin
            fail_msg("run_wait_expired", 0, 1);
            exp_q.delete();
            return;
        end
        if (drop) bus.req[owner] = 1'b0;
        seen = 0;
        for (int c = 0; c < TO + 8 && !seen; c++) begin
            @(negedge clk);
            seen = (bus.rsp_done != '0);
        end
        if (!seen) begin
            fail_msg("rsp_wait_expired", 0, 1);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "bench timed out");
    end

    // Stimulus: directed cases from the plan, then randomized transactions.
    initial begin
        bit seen;
        bus.req = '0;
        bus.core_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst = 1'b0;

        run_txn('0, 4'b0001, 0, 64, 0, 0);          // single request, 66-cycle core
        idle(3);
        run_txn('0, 4'b1000, 0, 3, 0, 0);           // leaves pointer at 3
        idle(2);
        run_txn('0, 4'b1111, 0, 5, 0, 0);           // fairness 0,1,2,3,0
        for (int i = 0; i < 4; i++) run_txn('0, 4'b1111, 0, 3 + i, 2, 0);
        idle(2);
        run_txn('0, 4'b1000, 0, 2, 0, 0);           // pointer wrap
        run_txn('0, 4'b1001, 0, 2, 2, 0);
        run_txn('0, 4'b1001, 0, 2, 2, 0);
        idle(2);
        run_txn('0, 4'b0100, 0, -1, 0, 0);          // timeout
        idle(2);
        run_txn('0, 4'b0010, 0, TO - 1, 0, 0);      // done on last watchdog cycle
        idle(2);
        run_txn('0, 4'b0010, 0, TO, 0, 0);          // done one cycle too late
        idle(2);
        run_txn(4'b0010, 4'b0010, 6, 10, 0, 0);     // core not ready
        idle(1);
        run_txn(4'b0110, 4'b0100, 5, 7, 0, 0);      // bit dropped before grant
        idle(2);
        run_txn('0, 4'b0011, 0, 12, 0, 1);          // owner drops req mid-way
        run_txn('0, 4'b0101, 0, 4, 2, 0);           // back-to-back

        // Reset while in WAIT: no completion, pointer back to NUM_REQ-1.
        idle(2);
        begin
            exp_t e;
            e.owner = pick(4'b0100); e.err = 1'b1; e.lat = TO + 1; e.gap = 0;
            exp_q.push_back(e);
        end
        done_delay = -1;
        bus.req = 4'b0100;
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = bus.core_run;
        end
        if (!seen) fail_msg("midrst_run_wait_expired", 0, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_check("midrst");
        rst = 1'b0;
        bus.req = '0;
        exp_q.delete();
        ptr_model = N - 1;
        repeat (10) begin
            @(negedge clk);
            chk("midrst_no_rsp_done", int'(bus.rsp_done), 0);
        end
        run_txn('0, 4'b1111, 0, 8, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] pat;
            int k, sel, idle_n;
            bit drop;
            pat    = N'($urandom_range(1, (1 << N) - 1));
            sel    = int'($urandom_range(0, 19));
            k      = (sel == 0) ? -1 : (sel == 1) ? TO - 1 : (sel == 2) ? TO
                   : int'($urandom_range(0, 30));
            drop   = ($urandom_range(0, 3) == 0);
            idle_n = int'($urandom_range(0, 2));
            if (idle_n > 0) idle(idle_n);
            run_txn('0, pat, 0, k, (idle_n == 0) ? 2 : 0, drop);
        end

        idle(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
